// File: rtl/branch_resolve_unit_if.sv
// rtl/branch_resolve_unit_if.sv - prediction, resolve, update and statistics bundle of the branch resolve unit
interface branch_resolve_unit_if #(
  parameter int PC_W  = 32,
  parameter int CNT_W = 16
);
  logic             pred_valid;
  logic             pred_taken;
  logic [PC_W-1:0]  pred_pc;
  logic [PC_W-1:0]  pred_target;
  logic             pred_ready;
  logic             res_valid;
  logic             res_taken;
  logic [PC_W-1:0]  res_target;
  logic             upd_enable;
  logic             upd_taken;
  logic             flush;
  logic [PC_W-1:0]  redirect_pc;
  logic             underflow;
  logic [CNT_W-1:0] branch_cnt;
  logic [CNT_W-1:0] mispred_cnt;

  modport master (
    output pred_valid, pred_taken, pred_pc, pred_target,
    output res_valid, res_taken, res_target,
    input  pred_ready, upd_enable, upd_taken, flush, redirect_pc,
    input  underflow, branch_cnt, mispred_cnt
  );

  modport slave (
    input  pred_valid, pred_taken, pred_pc, pred_target,
    input  res_valid, res_taken, res_target,
    output pred_ready, upd_enable, upd_taken, flush, redirect_pc,
    output underflow, branch_cnt, mispred_cnt
  );
endinterface

// File: rtl/branch_resolve_unit.sv
// rtl/branch_resolve_unit.sv - in-order matching of fetch predictions against execute outcomes
module branch_resolve_unit #(
  parameter int DEPTH = 4,
  parameter int PC_W  = 32,
  parameter int CNT_W = 16
) (
  input logic             clk,
  input logic             reset_n,
  branch_resolve_unit_if.slave bus
);
  localparam int              AW      = $clog2(DEPTH);
  localparam int              CW      = AW + 1;
  localparam logic [CW-1:0]   FULL    = CW'(DEPTH);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic            ent_taken_q [DEPTH];
  logic [PC_W-1:0] ent_pc_q    [DEPTH];
  logic [PC_W-1:0] ent_tgt_q   [DEPTH];

  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             upd_enable_q, upd_enable_d;
  logic             upd_taken_q, upd_taken_d;
  logic             flush_q, flush_d;
  logic [PC_W-1:0]  redirect_pc_q, redirect_pc_d;
  logic             underflow_q, underflow_d;
  logic [CNT_W-1:0] branch_cnt_q, branch_cnt_d;
  logic [CNT_W-1:0] mispred_cnt_q, mispred_cnt_d;

  logic            push, pop, mispredict;
  logic            head_taken;
  logic [PC_W-1:0] head_pc, head_tgt, redirect_calc;

  assign bus.pred_ready = (count_q != FULL);

  always_comb begin
    head_taken    = ent_taken_q[rd_ptr_q];
    head_pc       = ent_pc_q[rd_ptr_q];
    head_tgt      = ent_tgt_q[rd_ptr_q];
    push          = bus.pred_valid && bus.pred_ready;
    pop           = bus.res_valid && (count_q != '0);
    mispredict    = pop && ((head_taken != bus.res_taken) ||
                            (bus.res_taken && (head_tgt != bus.res_target)));
    redirect_calc = bus.res_taken ? bus.res_target : head_pc + PC_W'(4);
  end

  // A mispredict squashes every younger entry, including one pushed this cycle.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (mispredict) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
      if (push && !pop)      count_d = count_q + 1'b1;
      else if (pop && !push) count_d = count_q - 1'b1;
    end
  end

  always_comb begin
    upd_enable_d  = pop;
    upd_taken_d   = pop ? bus.res_taken : upd_taken_q;
    flush_d       = mispredict;
    redirect_pc_d = mispredict ? redirect_calc : redirect_pc_q;
    underflow_d   = underflow_q | (bus.res_valid && (count_q == '0));
    branch_cnt_d  = (pop && (branch_cnt_q != CNT_MAX)) ? branch_cnt_q + 1'b1 : branch_cnt_q;
    mispred_cnt_d = (mispredict && (mispred_cnt_q != CNT_MAX)) ? mispred_cnt_q + 1'b1
                                                               : mispred_cnt_q;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      count_q       <= '0;
      upd_enable_q  <= 1'b0;
      upd_taken_q   <= 1'b0;
      flush_q       <= 1'b0;
      redirect_pc_q <= '0;
      underflow_q   <= 1'b0;
      branch_cnt_q  <= '0;
      mispred_cnt_q <= '0;
    end else begin
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      count_q       <= count_d;
      upd_enable_q  <= upd_enable_d;
      upd_taken_q   <= upd_taken_d;
      flush_q       <= flush_d;
      redirect_pc_q <= redirect_pc_d;
      underflow_q   <= underflow_d;
      branch_cnt_q  <= branch_cnt_d;
      mispred_cnt_q <= mispred_cnt_d;
    end
  end

  // Entry storage carries no reset; only the pointers define what is valid.
  always_ff @(posedge clk) begin
    if (push && !mispredict) begin
      ent_taken_q[wr_ptr_q] <= bus.pred_taken;
      ent_pc_q[wr_ptr_q]    <= bus.pred_pc;
      ent_tgt_q[wr_ptr_q]   <= bus.pred_target;
    end
  end

  assign bus.upd_enable  = upd_enable_q;
  assign bus.upd_taken   = upd_taken_q;
  assign bus.flush       = flush_q;
  assign bus.redirect_pc = redirect_pc_q;
  assign bus.underflow   = underflow_q;
  assign bus.branch_cnt  = branch_cnt_q;
  assign bus.mispred_cnt = mispred_cnt_q;
endmodule

// File: doc/branch_resolve_unit.md
# branch_resolve_unit

Resolution-side counterpart to the front-end branch predictor. It queues each prediction issued at fetch, and matches it in order against the actual outcome computed in execute. It then drives the predictor's update port (`upd_enable`/`upd_taken`), raises a pipeline flush and redirect PC on a misprediction, and keeps branch and mispredict statistics counters.

## Interface
- `DEPTH`, 4: in-flight prediction FIFO entries (power of 2, ≥2).
- `PC_W`, 32: PC/target width.
- `CNT_W`, 16: statistics counter width.

- `clk`  in  1  clock, rising edge.
- `reset_n`  in  1  reset, asynchronous, active-low.
- `pred_valid`  in  1  fetch pushes a prediction this cycle.
- `pred_taken`  in  1  predicted direction.
- `pred_pc`  in  PC_W  PC of the predicted branch.
- `pred_target`  in  PC_W  predicted taken target.
- `pred_ready`  out  1  FIFO not full.
- `res_valid`  in  1  execute resolves the oldest branch.
- `res_taken`  in  1  actual direction.
- `res_target`  in  PC_W  actual taken target.
- `upd_enable`  out  1  predictor update strobe (registered).
- `upd_taken`  out  1  actual direction for the predictor (registered).
- `flush`  out  1  one-cycle mispredict flush (registered).
- `redirect_pc`  out  PC_W  correct fetch PC, valid while `flush`=1.
- `underflow`  out  1  sticky: `res_valid` arrived while the FIFO was empty.
- `branch_cnt`  out  CNT_W  resolved branches, saturating.
- `mispred_cnt`  out  CNT_W  mispredictions, saturating.

## Operation
- **FIFO.** Each entry holds {taken, pc, target}. It has read/write pointers of log2(DEPTH) bits that wrap, plus a count of log2(DEPTH)+1 bits.
  - `pred_ready` = (count != DEPTH).
- **Push.** A push occurs when `pred_valid && pred_ready`. `pred_valid` while full is ignored; the entry is dropped and state is unchanged.
- **Pop.** A pop occurs when `res_valid` and count>0. The popped entry is compared combinationally against the resolve inputs.
- **Mispredict.** `mispredict` = (entry.taken != `res_taken`) OR (`res_taken` && entry.target != `res_target`).
- **Redirect.** `redirect_pc` = `res_target` if `res_taken`, else entry.pc + 4 (mod 2^PC_W).
- **On a valid pop:**
  - `upd_enable`←1 and `upd_taken`←`res_taken` next cycle.
  - `branch_cnt`+1, saturating at all-ones.
  - If mispredict: `flush`←1, `redirect_pc` latched, `mispred_cnt`+1 (saturating), and the FIFO is cleared (pointers and count ←0), because all younger entries are wrong-path.
- **Simultaneous push and pop:**
  - Without mispredict: count is unchanged and both pointers advance.
  - With mispredict: the clear wins and the pushed entry is discarded (wrong-path).
- **Empty resolve.** `res_valid` with count=0 sets `underflow`, which stays set until reset. There is no update, no flush and no counter change.
- **Idle.** With no pop, `upd_enable` and `flush` are 0. `upd_taken` and `redirect_pc` hold their last value.

## Timing
- Reset (asynchronous, `reset_n`=0) forces:
  - Pointers and count to 0, so `pred_ready`=1.
  - `upd_enable`=0, `upd_taken`=0, `flush`=0, `redirect_pc`=0, `underflow`=0, `branch_cnt`=0, `mispred_cnt`=0.
  - FIFO contents are don't-care.
- Reset mid-operation discards all in-flight entries. Any flush that would have been generated is lost.
- **Latency.** `res_valid` sampled at edge N produces `upd_enable`/`flush`/`redirect_pc` high during cycle N+1, for exactly one cycle per resolve.
  - Back-to-back resolves give back-to-back strobes.
  - After a flush, the FIFO is empty from cycle N+1.
- **Ready.** `pred_ready` is derived from the registered count only (no combinational path from `res_valid`). A pop does not free a slot for a push in the same cycle when full.
- **Counters.** Counters and `underflow` update at edge N, i.e. they are visible in cycle N+1.

## Test plan
- **Reset.** Assert `reset_n`=0 mid-stream with 3 entries queued → all outputs at reset values immediately (asynchronous); `pred_ready`=1; next `res_valid` sets `underflow`=1.
- **Correct predictions.** Push {T, pc=0x100, tgt=0x200}, then resolve taken/0x200 → `upd_enable`=1, `upd_taken`=1, `flush`=0, `branch_cnt`=1, `mispred_cnt`=0.
- **Direction mispredict.**
  - Push {NT, pc=0x100}, {T, pc=0x104}, then resolve taken/0x300 → `flush`=1, `redirect_pc`=0x300, `mispred_cnt`=1, FIFO empty.
  - Push {T, pc=0x1FC}, resolve not-taken → `redirect_pc`=0x200.
- **Target mispredict.** Push {T, pc=0x10, tgt=0x80}, resolve taken/0x90 → `flush`=1, `redirect_pc`=0x90, `upd_taken`=1.
- **Full.** With DEPTH=4:
  - Push 4 entries → `pred_ready`=0; a 5th push is ignored; 4 correct resolves in order → 4 `upd_enable` pulses, no flush.
  - Simultaneous push and mispredicting pop → FIFO count 0 afterwards.
- **Saturation and wrap.** With CNT_W=4, run 20 mispredicting resolves → `mispred_cnt`=`branch_cnt`=15. Pointer wrap is verified across 3×DEPTH correctly predicted branches.
